// File: rtl/elevator_if.sv
// Signal bundle between the three-floor elevator controller and its
// surroundings.
//   I0..I2 : cabin call buttons for floors 0..2 (level, active-high)
//   E0..E2 : landing call buttons for floors 0..2 (level, active-high)
//   S0..S2 : cabin-at-floor sensors for floors 0..2 (active-high)
//   R      : passenger ready / close-door request
//   M      : motor enable
//   D      : travel direction (1 = up, 0 = down), 0 whenever M = 0
//   P      : door open
//   W      : waiting for R
//   S      : one-cycle arrival pulse
// The controller uses the slave modport; the environment uses master.
interface elevator_if;
    logic I0;
    logic I1;
    logic I2;
    logic E0;
    logic E1;
    logic E2;
    logic S0;
    logic S1;
    logic S2;
    logic R;
    logic M;
    logic D;
    logic P;
    logic W;
    logic S;

    modport slave (
        input  I0, I1, I2, E0, E1, E2, S0, S1, S2, R,
        output M, D, P, W, S
    );

    modport master (
        output I0, I1, I2, E0, E1, E2, S0, S1, S2, R,
        input  M, D, P, W, S
    );
endinterface

// File: rtl/elevator.sv
// Moore controller for a three-floor elevator (floors 0, 1, 2).
// Ports:
//   Clk   : system clock, all updates on the rising edge
//   Reset : synchronous, active-low; forces the locate state
//   bus   : elevator_if.slave carrying calls, sensors, R and the
//           M/D/P/W/S outputs
// The outputs are held in flops that are loaded with the decode of the
// next state, so after every edge they equal the decode of the state
// register and there is no combinational path from inputs to outputs.
module elevator (
    input  logic       Clk,
    input  logic       Reset,
    elevator_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_A = 4'd0,   // locate floor
        ST_B = 4'd1,   // idle at floor 0
        ST_C = 4'd2,   // idle at floor 1
        ST_D = 4'd3,   // idle at floor 2
        ST_E = 4'd4,   // door open, waiting for R
        ST_F = 4'd5,   // up 0->2, before floor 1
        ST_G = 4'd6,   // up 1->2
        ST_H = 4'd7,   // up 0->1
        ST_I = 4'd8,   // up, past floor 1
        ST_J = 4'd9,   // down 1->0
        ST_K = 4'd10,  // down 2->0, before floor 1
        ST_L = 4'd11,  // down, past floor 1
        ST_M = 4'd12,  // down 2->1
        ST_P = 4'd13,  // arrived
        ST_T = 4'd14,  // door closing
        ST_U = 4'd15   // door opening
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic c0_s;
    logic c1_s;
    logic c2_s;

    logic m_r;
    logic d_r;
    logic p_r;
    logic w_r;
    logic s_r;

    logic m_next_s;
    logic d_next_s;
    logic p_next_s;
    logic w_next_s;
    logic s_next_s;

    // A floor is requested when either its cabin or landing button is held.
    assign c0_s = bus.I0 | bus.E0;
    assign c1_s = bus.I1 | bus.E1;
    assign c2_s = bus.I2 | bus.E2;

    // State register and output flops; reset wins over every transition.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= ST_A;
            m_r     <= 1'b0;
            d_r     <= 1'b0;
            p_r     <= 1'b0;
            w_r     <= 1'b0;
            s_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            m_r     <= m_next_s;
            d_r     <= d_next_s;
            p_r     <= p_next_s;
            w_r     <= w_next_s;
            s_r     <= s_next_s;
        end
    end

    // Next-state logic; any condition not listed holds the current state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_A: begin
                if (bus.S0) begin
                    next_state_s = ST_B;
                end else if (bus.S1) begin
                    next_state_s = ST_C;
                end else if (bus.S2) begin
                    next_state_s = ST_D;
                end else begin
                    next_state_s = state_r;
                end
            end
            // Idle states: a call at the current floor wins, then the
            // farther/other floors in fixed priority order.
            ST_B: begin
                if (c0_s) begin
                    next_state_s = ST_P;
                end else if (c2_s) begin
                    next_state_s = ST_F;
                end else if (c1_s) begin
                    next_state_s = ST_H;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_C: begin
                if (c1_s) begin
                    next_state_s = ST_P;
                end else if (c2_s) begin
                    next_state_s = ST_G;
                end else if (c0_s) begin
                    next_state_s = ST_J;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_D: begin
                if (c2_s) begin
                    next_state_s = ST_P;
                end else if (c0_s) begin
                    next_state_s = ST_K;
                end else if (c1_s) begin
                    next_state_s = ST_M;
                end else begin
                    next_state_s = state_r;
                end
            end
            // Moving states watch only the sensor they are heading for.
            ST_F: begin
                if (bus.S1) begin
                    next_state_s = ST_I;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_I: begin
                if (bus.S2) begin
                    next_state_s = ST_P;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_H: begin
                if (bus.S1) begin
                    next_state_s = ST_P;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_G: begin
                if (bus.S2) begin
                    next_state_s = ST_P;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_J: begin
                if (bus.S0) begin
                    next_state_s = ST_P;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_K: begin
                if (bus.S1) begin
                    next_state_s = ST_L;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_L: begin
                if (bus.S0) begin
                    next_state_s = ST_P;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_M: begin
                if (bus.S1) begin
                    next_state_s = ST_P;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_P: next_state_s = ST_U;
            ST_U: next_state_s = ST_E;
            ST_E: begin
                if (bus.R) begin
                    next_state_s = ST_T;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_T: next_state_s = ST_A;
            default: next_state_s = ST_A;
        endcase
    end

    // Output decode of the state being entered; loaded into the output flops.
    always_comb begin
        m_next_s = 1'b0;
        d_next_s = 1'b0;
        p_next_s = 1'b0;
        w_next_s = 1'b0;
        s_next_s = 1'b0;
        case (next_state_s)
            ST_F, ST_I, ST_H, ST_G: begin
                m_next_s = 1'b1;
                d_next_s = 1'b1;
            end
            ST_J, ST_K, ST_L, ST_M: begin
                m_next_s = 1'b1;
                d_next_s = 1'b0;
            end
            ST_P: begin
                p_next_s = 1'b1;
                s_next_s = 1'b1;
            end
            ST_U: begin
                p_next_s = 1'b1;
            end
            ST_E: begin
                p_next_s = 1'b1;
                w_next_s = 1'b1;
            end
            default: begin
                m_next_s = 1'b0;
                d_next_s = 1'b0;
                p_next_s = 1'b0;
                w_next_s = 1'b0;
                s_next_s = 1'b0;
            end
        endcase
    end

    assign bus.M = m_r;
    assign bus.D = d_r;
    assign bus.P = p_r;
    assign bus.W = w_r;
    assign bus.S = s_r;

endmodule

// File: tb/tb_elevator.sv
// Randomized, scoreboard-checked bench for the elevator controller.
// The reference model tracks the cabin in terms of phase, floor, target
// floor and direction; each cycle it pushes the expected {M,D,P,W,S} and a
// separate monitor pops and compares it against the DUT after the edge.
module tb_elevator;

    logic clk;
    logic rst;

    elevator_if bus ();

    elevator dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [4:0] exp_q[$];

    // Reference model state
    localparam int PH_LOCATE = 0;
    localparam int PH_IDLE   = 1;
    localparam int PH_MOVE   = 2;
    localparam int PH_DOOR   = 3;
    localparam int PH_CLOSE  = 4;

    int phase    = PH_LOCATE;
    int floor_no = 0;
    int target   = 0;
    int door_cnt = 0;
    bit going_up = 1'b0;

    // Destination chosen from an idle floor when the current floor is not called.
    function automatic int pick_target(int fl, logic [2:0] c);
        int t;
        t = -1;
        if (fl == 0) begin
            if (c[2]) t = 2; else if (c[1]) t = 1;
        end else if (fl == 1) begin
            if (c[2]) t = 2; else if (c[0]) t = 0;
        end else begin
            if (c[0]) t = 0; else if (c[1]) t = 1;
        end
        return t;
    endfunction

    function automatic logic [4:0] model_out();
        logic m, d, p, w, s;
        m = (phase == PH_MOVE);
        d = (phase == PH_MOVE) && going_up;
        p = (phase == PH_DOOR);
        s = (phase == PH_DOOR) && (door_cnt == 0);
        w = (phase == PH_DOOR) && (door_cnt == 2);
        return {m, d, p, w, s};
    endfunction

    task automatic model_step(input logic [2:0] iv, input logic [2:0] ev,
                              input logic [2:0] sv, input logic r,
                              input logic rst_v);
        logic [2:0] c;
        int nxt;
        int t;
        c = iv | ev;
        if (!rst_v) begin
            phase = PH_LOCATE;
        end else begin
            case (phase)
                PH_LOCATE: begin
                    if (sv[0]) begin phase = PH_IDLE; floor_no = 0; end
                    else if (sv[1]) begin phase = PH_IDLE; floor_no = 1; end
                    else if (sv[2]) begin phase = PH_IDLE; floor_no = 2; end
                end
                PH_IDLE: begin
                    if (c[floor_no]) begin
                        phase = PH_DOOR;
                        door_cnt = 0;
                    end else begin
                        t = pick_target(floor_no, c);
                        if (t >= 0) begin
                            target = t;
                            going_up = (t > floor_no);
                            phase = PH_MOVE;
                        end
                    end
                end
                PH_MOVE: begin
                    nxt = going_up ? floor_no + 1 : floor_no - 1;
                    if (sv[nxt]) begin
                        floor_no = nxt;
                        if (floor_no == target) begin
                            phase = PH_DOOR;
                            door_cnt = 0;
                        end
                    end
                end
                PH_DOOR: begin
                    if (door_cnt < 2) door_cnt++;
                    else if (r) phase = PH_CLOSE;
                end
                default: phase = PH_LOCATE;
            endcase
        end
    endtask

    // One clock: drive at negedge, update model at posedge, queue expectation.
    task automatic step(input logic [2:0] iv, input logic [2:0] ev,
                        input logic [2:0] sv, input logic r, input logic rst_v);
        @(negedge clk);
        {bus.I2, bus.I1, bus.I0} = iv;
        {bus.E2, bus.E1, bus.E0} = ev;
        {bus.S2, bus.S1, bus.S0} = sv;
        bus.R = r;
        rst   = rst_v;
        @(posedge clk);
        model_step(iv, ev, sv, r, rst_v);
        exp_q.push_back(model_out());
    endtask

    // Monitor: compare every presented output vector against the queue head.
    initial begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {bus.M, bus.D, bus.P, bus.W, bus.S};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d MDPWS actual=%b expected=%b",
                             cyc, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        logic [2:0] iv, ev, sv;
        logic r, rv;
        bus.I0 = 1'b0; bus.I1 = 1'b0; bus.I2 = 1'b0;
        bus.E0 = 1'b0; bus.E1 = 1'b0; bus.E2 = 1'b0;
        bus.S0 = 1'b0; bus.S1 = 1'b0; bus.S2 = 1'b0;
        bus.R  = 1'b0;
        rst    = 1'b0;

        // Directed walk through the main scenarios.
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b000, 3'b000, 3'b001, 1'b0, 1'b1);   // a -> b
        step(3'b000, 3'b001, 3'b000, 1'b0, 1'b1);   // E0 -> p
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);   // u
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);   // e
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);   // hold e
        step(3'b000, 3'b000, 3'b000, 1'b1, 1'b1);   // t
        step(3'b000, 3'b000, 3'b001, 1'b0, 1'b1);   // a -> b
        step(3'b100, 3'b010, 3'b000, 1'b0, 1'b1);   // priority -> f
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);   // hold f
        step(3'b000, 3'b000, 3'b010, 1'b0, 1'b1);   // i
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);   // hold i
        step(3'b000, 3'b000, 3'b100, 1'b0, 1'b1);   // p
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b000, 3'b000, 3'b000, 1'b1, 1'b1);   // t
        step(3'b000, 3'b000, 3'b100, 1'b0, 1'b1);   // a -> d
        step(3'b000, 3'b001, 3'b000, 1'b0, 1'b1);   // k
        step(3'b000, 3'b000, 3'b010, 1'b0, 1'b1);   // l
        step(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);   // reset mid-travel

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            iv = '0; ev = '0; sv = '0;
            for (int b = 0; b < 3; b++) begin
                iv[b] = ($urandom_range(99) < 12);
                ev[b] = ($urandom_range(99) < 12);
                sv[b] = ($urandom_range(99) < 25);
            end
            r  = ($urandom_range(99) < 30);
            rv = ($urandom_range(99) >= 2);
            step(iv, ev, sv, r, rv);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain queue_left actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator.md
# elevator

Moore-type controller for a three-floor elevator (floors 0, 1, 2). It takes cabin and landing call buttons, floor-position sensors and a passenger-ready input. From these it drives the motor, travel direction, door, wait indicator and arrival signal. It is the top-level control ASM of the elevator design and has no submodules.

## Interface
- No parameters.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low; forces state `a` on the next rising edge while 0.
- I0, I1, I2  in  1 each  cabin (internal) call for floor 0/1/2, level-sensitive, active-high.
- E0, E1, E2  in  1 each  landing (external) call for floor 0/1/2, level-sensitive, active-high.
- S0, S1, S2  in  1 each  cabin-at-floor sensor for floor 0/1/2, active-high.
- R  in  1  passenger ready / close-door request, active-high.
- M  out  1  motor enable.
- D  out  1  direction: 1 = up, 0 = down; 0 whenever M = 0.
- P  out  1  door open.
- W  out  1  waiting for R.
- S  out  1  arrival signal, one cycle.

## Operation
- Outputs are a pure decode of the state register (Moore). There is no combinational input-to-output path.
- There are 16 states, with 4-bit binary encoding.
- All unlisted conditions hold the current state.
- Call for floor n: Cn = In | En.

**State transitions**
- a (locate floor): S0 → b; else S1 → c; else S2 → d.
- b (idle at floor 0): C0 → p; else C2 → f; else C1 → h.
- c (idle at floor 1): C1 → p; else C2 → g; else C0 → j.
- d (idle at floor 2): C2 → p; else C0 → k; else C1 → m.
- f (up 0→2, before floor 1): S1 → i.
- i (up, past floor 1): S2 → p.
- h (up 0→1): S1 → p.
- g (up 1→2): S2 → p.
- j (down 1→0): S0 → p.
- k (down 2→0, before floor 1): S1 → l.
- l (down, past floor 1): S0 → p.
- m (down 2→1): S1 → p.
- p (arrived): unconditional → u.
- u (door opening): unconditional → e.
- e (door open, waiting): R → t.
- t (door closing): unconditional → a.

**Output decode** (outputs not listed are 0)
- M=1, D=1 in f, i, h, g.
- M=1, D=0 in j, k, l, m.
- P=1 in p, u, e.
- S=1 in p only.
- W=1 in e only.
- All outputs are 0 in a, b, c, d, t.

**Rules**
- Calls are not latched. A call must be present in an idle state on a clock edge to be served.
- Calls asserted in other states are ignored.
- Sensors other than the one a moving state waits on are ignored.
- An unused state code → a on the next edge, with all outputs 0.

## Timing
- Reset low on a rising edge → state a, all outputs 0 after that edge. This applies mid-operation too, including while the motor runs.
- Reset has priority over every transition.
- One transition per clock edge. Outputs change only after a rising edge.
- Arrival: the sensor is sampled high in a moving state → p on that edge, with P=S=1 for exactly one cycle.
- p → u → e takes 2 cycles. Within it, P stays high continuously from p through e.
- e holds indefinitely while R=0. R=1 → t, then a on the next edge.
- a re-localizes on the following edge if a sensor is high.
- From e with R=1 to reaching an idle state takes 3 edges (e→t→a→idle).
- Call at the current floor → p in 1 edge, with no motor activity.
- Simultaneous calls in an idle state follow the priority order listed above.

## Test plan
- Reset low, then high with all inputs 0 → remains a, all outputs 0. Then S0=1 for one edge → b.
- In b, E0=1 → p (P=1, S=1). Then u, then e (P=1, W=1). Holding R=0 for 2 edges keeps e. R=1 → t (P=0), then a.
- In b, I2=1 → f (M=1, D=1). S1=0 holds f. S1=1 → i; S2=0 holds i. S2=1 → p.
- In b, E1=1 with all other inputs 0 → h (M=1, D=1). S1=1 → p.
- In b, I2=1 and E1=1 together → f (priority).
- From a with S0=0, S1=1 → c. Zero inputs hold c. I0=1 → j (M=1, D=0). S0=1 → p → u → e. R=1 → t → a. Zero inputs hold a.
- In d, E0=1 → k → (S1) l → (S0) p, with M=1, D=0 throughout. Reset=0 asserted in l → a, M=0 after that edge.
